fft_bitrev_frame_buffer: RTL
============================

# fft_bitrev_frame_buffer

Parametrised ping-pong frame buffer that sits between the sample source and the radix-2 FFT core. It accepts a stream of complex samples, groups them into frames of N = 2^LOG2N points, and replays each frame in bit-reversed or natural order with valid/ready backpressure on both sides. It generalises the fixed 256-point, 16-bit, no-backpressure input path to any power-of-two depth and data width, and sustains full-rate streaming.

## Interface
- DATA_W, 16, width of each real and imaginary component, two's complement
- LOG2N, 8, log2 of frame length N; legal range 2..12
- BITREV, 1, 1 = output in bit-reversed address order, 0 = natural order
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  buffer can accept a sample this cycle
- in_re / in_im  in  DATA_W each  input sample
- in_last  in  1  source marks last sample of frame; checked only, never used for framing
- out_valid  out  1  output sample valid
- out_ready  in  1  consumer accepts output this cycle
- out_re / out_im  out  DATA_W each  output sample
- out_index  out  LOG2N  buffer address of the output sample
- out_first / out_last  out  1  first / last output sample of a frame
- frame_err  out  1  one-cycle pulse on in_last mismatch

## Operation
- Storage: two banks (0, 1), each N x 2·DATA_W; per-bank flag full[b].
- Write side: pointer wr_bank, counter wr_idx (LOG2N bits). in_ready = !full[wr_bank] (combinational).
- Accept (in_valid && in_ready): mem[wr_bank][wr_idx] <= {in_re, in_im}; wr_idx++. When wr_idx == N-1: full[wr_bank] <= 1, wr_bank toggles, wr_idx wraps to 0.
- frame_err pulses the cycle after an accept where in_last != (wr_idx == N-1). Framing is by count only; the frame still closes at N samples.
- Read side: pointer rd_bank, counter rd_idx. Load condition: full[rd_bank] && (!out_valid || out_ready).
- On load: addr = BITREV ? bit-reverse(rd_idx) : rd_idx; out_re/out_im <= mem[rd_bank][addr]; out_index <= addr; out_first <= (rd_idx == 0); out_last <= (rd_idx == N-1); out_valid <= 1; rd_idx++.
- Load with rd_idx == N-1: full[rd_bank] <= 0, rd_bank toggles, rd_idx wraps.
- No load && out_ready: out_valid <= 0. Out data holds while out_valid && !out_ready.
- A write and a clear never target the same bank in one cycle (write requires !full), so set/clear cannot collide.
- Data is passed bit-exact; no arithmetic or scaling.

## Timing
- Reset values: out_valid 0, out_re/out_im 0, out_index 0, out_first/out_last 0, frame_err 0, full[] 0, all pointers and counters 0. in_ready is 1 immediately after reset.
- Reset mid-frame discards partial and buffered frames. Memory contents need not be cleared.
- Latency: last sample of a frame accepted at edge k; out_valid with first sample rises at edge k+1.
- Throughput: with out_ready held 1, one sample per cycle in and out indefinitely. After the first frame, in_ready never drops.
- Backpressure: with out_ready low, at most 2 frames are buffered. in_ready drops once both banks are full and rises the cycle after the clearing load frees a bank.
- out_first/out_last are valid only while out_valid = 1.

## Test plan
- LOG2N=3, BITREV=1, ramp 0..7 (im = re+100) with out_ready=1 -> out_re 0,4,2,6,1,5,3,7; out_index equals out_re. out_first on 0, out_last on 7. out_valid rises 1 cycle after sample 7 is accepted.
- LOG2N=3, BITREV=0, same ramp -> natural order 0..7. Then 4 back-to-back frames at full rate: in_ready stays 1 after reset, no gaps on the output.
- LOG2N=3, out_ready=0, stream 24 samples -> in_ready drops after 16 accepts. Release out_ready -> frame 1 drains, then frame 2, then frame 3. No loss or duplication. Output stable while stalled.
- in_last asserted at sample 5 of an 8-point frame -> frame_err pulses once. Frame still closes after sample 7, and frame_err pulses again because in_last is low at sample 7.
- Reset asserted mid-drain (after 3 outputs) -> all outputs 0 asynchronously, in_ready 1. A new ramp frame then replays correctly from index 0.
- Default params (DATA_W=16, LOG2N=8), random 256-point frames from a file -> output equals the reference model's bit-reversed permutation exactly.

Source files
------------

// File: rtl/fft_bitrev_frame_buffer.sv
// Ping-pong N-point sample buffer replaying each frame in bit-reversed or natural order; first output one cycle after a frame's last accept.
// Valid/ready on both sides: in_ready_o falls only while both banks hold complete frames; output holds while out_ready_i is low.
module fft_bitrev_frame_buffer #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 8,
  parameter bit BITREV = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_re_i,
  input  logic [DATA_W-1:0] in_im_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_re_o,
  output logic [DATA_W-1:0] out_im_o,
  output logic [LOG2N-1:0]  out_index_o,
  output logic              out_first_o,
  output logic              out_last_o,
  output logic              frame_err_o
);
  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } sample_t;

  sample_t          mem_q [2][N];
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_idx_q, wr_idx_d;
  logic [LOG2N-1:0] rd_idx_q, rd_idx_d;
  sample_t          out_dat_q, out_dat_d;
  logic [LOG2N-1:0] out_index_q, out_index_d;
  logic             out_valid_q, out_valid_d;
  logic             out_first_q, out_first_d;
  logic             out_last_q, out_last_d;
  logic             frame_err_q, frame_err_d;

  logic             accept, load, wr_last, rd_last;
  logic [LOG2N-1:0] rd_addr;

  function automatic logic [LOG2N-1:0] bit_reverse(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  assign in_ready_o = !full_q[wr_bank_q];

  always_comb begin
    accept  = in_valid_i && in_ready_o;
    wr_last = (wr_idx_q == LAST_IDX);
    // Refill the output register when it is empty or being consumed this cycle.
    load    = full_q[rd_bank_q] && (!out_valid_q || out_ready_i);
    rd_last = (rd_idx_q == LAST_IDX);
    rd_addr = BITREV ? bit_reverse(rd_idx_q) : rd_idx_q;
  end

  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_bank_d   = rd_bank_q;
    rd_idx_d    = rd_idx_q;
    out_dat_d   = out_dat_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    frame_err_d = accept && (in_last_i != wr_last);

    if (accept) begin
      wr_idx_d = wr_idx_q + LOG2N'(1);
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end

    // A write targets a non-full bank and a clear a full one, so these never overlap.
    if (load) begin
      out_dat_d   = mem_q[rd_bank_q][rd_addr];
      out_index_d = rd_addr;
      out_first_d = (rd_idx_q == '0);
      out_last_d  = rd_last;
      out_valid_d = 1'b1;
      rd_idx_d    = rd_idx_q + LOG2N'(1);
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) mem_q[wr_bank_q][wr_idx_q] <= '{re: in_re_i, im: in_im_i};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      out_dat_q   <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      out_dat_q   <= out_dat_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_re_o    = out_dat_q.re;
  assign out_im_o    = out_dat_q.im;
  assign out_index_o = out_index_q;
  assign out_first_o = out_first_q;
  assign out_last_o  = out_last_q;
  assign frame_err_o = frame_err_q;

endmodule
